uart_time_parser: RTL and testbench

UART_TIME_PARSER -- requirements
Module: uart_time_parser

---
 rtl/uart_time_parser.sv | 194 +++++++++++++++++++
 tb/tb_uart_time_parser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_time_parser.sv
// uart_time_parser
// Checks a 17-byte ASCII frame "YY-MM-DD HH:MM:SS" and converts it to packed BCD.
// The frame is latched when the byte counter sees its last byte. It is then scanned
// one byte per clock, range-checked for one cycle, and reported as either a
// time_set or a frame_err pulse.
// Optional build macro: UART_TIME_PARSER_DAYCHK_EN selects the month-length
// day rule. When it is undefined, any day from 01 to 31 is accepted.
module uart_time_parser #(
    parameter int CHECK_SEP   = 1,
    parameter int FRAME_BYTES = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_rx_done,
    input  logic [FRAME_BYTES*8-1:0] uart_rx,
    output logic                     time_set,
    output logic                     frame_err,
    output logic                     busy,
    output logic [7:0]               yr_bcd,
    output logic [7:0]               mon_bcd,
    output logic [7:0]               day_bcd,
    output logic [7:0]               hr_bcd,
    output logic [7:0]               min_bcd,
    output logic [7:0]               sec_bcd
);
    localparam int       FW       = FRAME_BYTES * 8;
    localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RANGE  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [4:0]      r_cnt;
    logic [4:0]      r_idx;
    logic            r_err;
    logic [FW-1:0]   r_frame;
    logic            r_time_set;
    logic            r_frame_err;
    logic            r_busy;
    logic [47:0]     r_bcd;

    logic            w_frame_done;
    logic            w_drop;
    logic [7:0]      w_byte;
    logic [8:0]      w_sep;
    logic            w_scan_bad;
    logic [7:0]      w_yr, w_mon, w_day, w_hr, w_min, w_sec;
    logic [7:0]      w_day_max;
    logic [4:0]      w_yr_mod;
    logic            w_range_bad;
    logic            w_bad_total;

    // Byte idx of the frame; byte 0 sits in the most significant position.
    function automatic logic [7:0] byte_at(input logic [FW-1:0] f, input logic [4:0] idx);
        logic [FW-1:0] s;
        s = f << {idx, 3'b000};
        return s[FW-1 -: 8];
    endfunction

    // Two ASCII digits starting at idx folded into one packed BCD byte.
    function automatic logic [7:0] bcd_pair(input logic [FW-1:0] f, input logic [4:0] idx);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = byte_at(f, idx);
        lo = byte_at(f, idx + 5'd1);
        return {hi[3:0], lo[3:0]};
    endfunction

    // {is_separator, expected_character} for a byte position.
    function automatic logic [8:0] sep_at(input logic [4:0] idx);
        case (idx)
            5'd2, 5'd5:   return {1'b1, 8'h2D};
            5'd8:         return {1'b1, 8'h20};
            5'd11, 5'd14: return {1'b1, 8'h3A};
            default:      return {1'b0, 8'h00};
        endcase
    endfunction

    assign w_frame_done = uart_rx_done && (r_cnt == LAST_IDX);
    assign w_drop       = w_frame_done && (r_state != ST_IDLE);
    assign w_byte       = byte_at(r_frame, r_idx);
    assign w_sep        = sep_at(r_idx);

    assign w_yr  = bcd_pair(r_frame, 5'd0);
    assign w_mon = bcd_pair(r_frame, 5'd3);
    assign w_day = bcd_pair(r_frame, 5'd6);
    assign w_hr  = bcd_pair(r_frame, 5'd9);
    assign w_min = bcd_pair(r_frame, 5'd12);
    assign w_sec = bcd_pair(r_frame, 5'd15);

    // Binary year mod 4 equals (2*tens + ones) mod 4.
    assign w_yr_mod = {w_yr[7:4], 1'b0} + {1'b0, w_yr[3:0]};

    // Per-byte format check while scanning.
    always_comb begin
        w_scan_bad = 1'b0;
        if (r_state != ST_SCAN) begin
            w_scan_bad = 1'b0;
        end else if (w_sep[8]) begin
            w_scan_bad = (CHECK_SEP != 0) && (w_byte != w_sep[7:0]);
        end else begin
            w_scan_bad = (w_byte < 8'h30) || (w_byte > 8'h39);
        end
    end

    // Longest legal day for the latched month.
    always_comb begin
        w_day_max = 8'h31;
`ifdef UART_TIME_PARSER_DAYCHK_EN
        case (w_mon)
            8'h04, 8'h06, 8'h09, 8'h11: w_day_max = 8'h30;
            8'h02:                      w_day_max = (w_yr_mod[1:0] == 2'b00) ? 8'h29 : 8'h28;
            default:                    w_day_max = 8'h31;
        endcase
`else
        w_day_max = 8'h31;
`endif
    end

    assign w_range_bad = (w_mon == 8'h00) || (w_mon > 8'h12) ||
                         (w_day == 8'h00) || (w_day > w_day_max) ||
                         (w_hr > 8'h23) || (w_min > 8'h59) || (w_sec > 8'h59);
    assign w_bad_total = r_err || w_range_bad;

    // Next-state logic of the check sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   w_state_next = w_frame_done ? ST_SCAN : ST_IDLE;
            ST_SCAN:   w_state_next = (r_idx == LAST_IDX) ? ST_RANGE : ST_SCAN;
            ST_RANGE:  w_state_next = ST_REPORT;
            ST_REPORT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // State, counters, latched frame and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_idx   <= 5'd0;
            r_err   <= 1'b0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_next;
            if (uart_rx_done) begin
                r_cnt <= (r_cnt == LAST_IDX) ? 5'd0 : r_cnt + 5'd1;
            end
            if (r_state == ST_IDLE && w_frame_done) begin
                r_frame <= uart_rx;
            end
            r_idx <= (r_state == ST_SCAN && r_idx != LAST_IDX) ? r_idx + 5'd1 : 5'd0;
            case (r_state)
                ST_SCAN:  r_err <= r_err | w_scan_bad;
                ST_RANGE: r_err <= w_bad_total;
                default:  r_err <= 1'b0;
            endcase
        end
    end

    // Result pulses are produced from the RANGE verdict so they appear in the REPORT
    // cycle. A dropped frame overrides the result in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time_set  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
            r_bcd       <= 48'h0;
        end else begin
            r_time_set  <= (r_state == ST_RANGE) && !w_bad_total && !w_drop;
            r_frame_err <= ((r_state == ST_RANGE) && w_bad_total) || w_drop;
            r_busy      <= (w_state_next != ST_IDLE);
            if ((r_state == ST_RANGE) && !w_bad_total && !w_drop) begin
                r_bcd <= {w_yr, w_mon, w_day, w_hr, w_min, w_sec};
            end
        end
    end

    assign time_set  = r_time_set;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
    assign yr_bcd    = r_bcd[47:40];
    assign mon_bcd   = r_bcd[39:32];
    assign day_bcd   = r_bcd[31:24];
    assign hr_bcd    = r_bcd[23:16];
    assign min_bcd   = r_bcd[15:8];
    assign sec_bcd   = r_bcd[7:0];
endmodule

// File: tb/tb_uart_time_parser.sv
// Directed bench for uart_time_parser: two instances, separator check on (a) and off (b).
module tb_uart_time_parser;
`ifdef UART_TIME_PARSER_DAYCHK_EN
    localparam bit DAYCHK = 1'b1;
`else
    localparam bit DAYCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         uart_rx_done = 1'b0;
    logic [135:0] uart_rx = '0;

    logic ts_a, fe_a, busy_a, ts_b, fe_b, busy_b;
    logic [7:0] yr_a, mon_a, day_a, hr_a, min_a, sec_a;
    logic [7:0] yr_b, mon_b, day_b, hr_b, min_b, sec_b;
    wire  [47:0] t_a = {yr_a, mon_a, day_a, hr_a, min_a, sec_a};
    wire  [47:0] t_b = {yr_b, mon_b, day_b, hr_b, min_b, sec_b};

    logic [47:0] exp_a = 48'h0;
    logic [47:0] exp_b = 48'h0;
    int checks = 0;
    int errors = 0;

    uart_time_parser #(.CHECK_SEP(1), .FRAME_BYTES(17)) dut_a (
        .clk(clk), .rst_n(rst_n), .uart_rx_done(uart_rx_done), .uart_rx(uart_rx),
        .time_set(ts_a), .frame_err(fe_a), .busy(busy_a),
        .yr_bcd(yr_a), .mon_bcd(mon_a), .day_bcd(day_a),
        .hr_bcd(hr_a), .min_bcd(min_a), .sec_bcd(sec_a));

    uart_time_parser #(.CHECK_SEP(0), .FRAME_BYTES(17)) dut_b (
        .clk(clk), .rst_n(rst_n), .uart_rx_done(uart_rx_done), .uart_rx(uart_rx),
        .time_set(ts_b), .frame_err(fe_b), .busy(busy_b),
        .yr_bcd(yr_b), .mon_bcd(mon_b), .day_bcd(day_b),
        .hr_bcd(hr_b), .min_bcd(min_b), .sec_bcd(sec_b));

    always #5 clk = ~clk;

    // Drive 17 done pulses, then return at the latching posedge.
    task automatic send_bytes(input logic [135:0] f);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            uart_rx      = f;
            uart_rx_done = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ts_a, fe_a, busy_a, ts_b, fe_b, busy_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000", {ts_a, fe_a, busy_a, ts_b, fe_b, busy_b});
        end
        checks++;
        if (t_a !== 48'h0 || t_b !== 48'h0) begin
            errors++;
            $display("FAIL reset_bcd got a=%h b=%h want 0", t_a, t_b);
        end
        rst_n = 1'b1;
    endtask

    // One frame; result expected in cycle 19 after the latching edge.
    task automatic test_frame(input string name, input logic [135:0] f,
                              input bit ok_a, input bit ok_b, input logic [47:0] t_new);
        send_bytes(f);
        if (ok_a) exp_a = t_new;
        if (ok_b) exp_b = t_new;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            uart_rx_done = 1'b0;
            checks++;
            if (ts_a !== (c == 19 && ok_a) || fe_a !== (c == 19 && !ok_a) || busy_a !== (c <= 19)) begin
                errors++;
                $display("FAIL %s_a cycle %0d got ts/fe/busy=%b%b%b want %b%b%b", name, c,
                         ts_a, fe_a, busy_a, (c == 19 && ok_a), (c == 19 && !ok_a), (c <= 19));
            end
            checks++;
            if (ts_b !== (c == 19 && ok_b) || fe_b !== (c == 19 && !ok_b) || busy_b !== (c <= 19)) begin
                errors++;
                $display("FAIL %s_b cycle %0d got ts/fe/busy=%b%b%b want %b%b%b", name, c,
                         ts_b, fe_b, busy_b, (c == 19 && ok_b), (c == 19 && !ok_b), (c <= 19));
            end
        end
        checks++;
        if (t_a !== exp_a) begin
            errors++;
            $display("FAIL %s_bcd_a got=%h want=%h", name, t_a, exp_a);
        end
        checks++;
        if (t_b !== exp_b) begin
            errors++;
            $display("FAIL %s_bcd_b got=%h want=%h", name, t_b, exp_b);
        end
    endtask

    // A second frame completes at cycle 17 (SCAN): dropped, error at 18, first still reports.
    task automatic test_back_to_back();
        send_bytes("24-05-01 12:30:45");
        exp_a = 48'h240501123045;
        exp_b = 48'h240501123045;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            checks++;
            if (ts_a !== (c == 19) || fe_a !== (c == 18) || ts_b !== (c == 19) || fe_b !== (c == 18)) begin
                errors++;
                $display("FAIL b2b cycle %0d got ts_a/fe_a/ts_b/fe_b=%b%b%b%b", c, ts_a, fe_a, ts_b, fe_b);
            end
            uart_rx      = "99-12-31 23:59:59";
            uart_rx_done = (c <= 17);
        end
        checks++;
        if (t_a !== exp_a || t_b !== exp_b) begin
            errors++;
            $display("FAIL b2b_bcd got a=%h b=%h want %h", t_a, t_b, exp_a);
        end
    endtask

    // The dropped frame completes in RANGE: result pulse replaced by frame_err at 19.
    task automatic test_collide_report();
        send_bytes("25-06-15 08:09:10");
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            checks++;
            if (ts_a !== 1'b0 || fe_a !== (c == 19) || ts_b !== 1'b0 || fe_b !== (c == 19)) begin
                errors++;
                $display("FAIL collide cycle %0d got ts_a/fe_a/ts_b/fe_b=%b%b%b%b", c, ts_a, fe_a, ts_b, fe_b);
            end
            uart_rx_done = (c >= 2 && c <= 18);
        end
        checks++;
        if (t_a !== exp_a || t_b !== exp_b) begin
            errors++;
            $display("FAIL collide_bcd got a=%h b=%h want a=%h b=%h", t_a, t_b, exp_a, exp_b);
        end
    endtask

    // Reset while scanning byte 8 aborts the frame with no pulse.
    task automatic test_reset_mid_scan();
        send_bytes("24-05-01 12:30:45");
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            uart_rx_done = 1'b0;
        end
        rst_n = 1'b0;
        exp_a = 48'h0;
        exp_b = 48'h0;
        #1;
        checks++;
        if ({ts_a, fe_a, busy_a, ts_b, fe_b, busy_b} !== 6'b0 || t_a !== 48'h0 || t_b !== 48'h0) begin
            errors++;
            $display("FAIL midscan_reset got flags=%b a=%h b=%h want 0", {ts_a, fe_a, busy_a, ts_b, fe_b, busy_b}, t_a, t_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({ts_a, fe_a, busy_a, ts_b, fe_b, busy_b} !== 6'b0) begin
                errors++;
                $display("FAIL midscan_quiet cycle %0d got=%b want=000000", c, {ts_a, fe_a, busy_a, ts_b, fe_b, busy_b});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame("basic",    "24-05-01 12:30:45", 1'b1, 1'b1, 48'h240501123045);
        test_frame("bad_mon",  "24-13-01 12:30:45", 1'b0, 1'b0, 48'h0);
        test_frame("max_time", "24-12-31 23:59:59", 1'b1, 1'b1, 48'h241231235959);
        test_frame("bad_sep",  "24-05-01 12.30:45", 1'b0, 1'b1, 48'h240501123045);
        test_frame("bad_hr",   "24-05-01 24:00:00", 1'b0, 1'b0, 48'h0);
        test_frame("bad_dig",  "24-05-0/ 12:30:45", 1'b0, 1'b0, 48'h0);
        test_frame("day00",    "24-05-00 12:30:45", 1'b0, 1'b0, 48'h0);
        test_frame("feb29_23", "23-02-29 00:00:00", !DAYCHK, !DAYCHK, 48'h230229000000);
        test_frame("feb29_24", "24-02-29 00:00:00", 1'b1, 1'b1, 48'h240229000000);
        test_frame("apr31",    "24-04-31 10:00:00", !DAYCHK, !DAYCHK, 48'h240431100000);
        test_back_to_back();
        test_collide_report();
        test_reset_mid_scan();
        test_frame("post_rst", "07-11-30 01:02:03", 1'b1, 1'b1, 48'h071130010203);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
